bpsk_modulator: RTL and testbench

// - Parametrised BPSK transmitter: accepts bytes over a valid/ready stream, buffers them in a FIFO,

---
 rtl/bpsk_pkg.sv | 27 ++
 rtl/bpsk_sine_lut.sv | 34 +++
 rtl/bpsk_modulator.sv | 183 ++++++++++++++++++
 tb/tb_bpsk_modulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared FSM type, byte width, sine table and offset helpers, and the
// parameter legality check used by the BPSK blocks.
package bpsk_pkg;
    typedef enum logic {IDLE, SEND} state_t;

    localparam int BYTE_WIDTH = 8;
    localparam real PI = 3.14159265358979323846;

    function automatic bit bpsk_params_ok(int data_width, int wavelength, int cycles_per_sample,
                                          int carriers_per_bit, int fifo_depth);
        return data_width >= 2 && wavelength >= 4 && wavelength % 2 == 0 && cycles_per_sample >= 1
            && carriers_per_bit >= 1 && fifo_depth >= 2 && (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction

    // Offset-binary sine sample k of a full period, rounded to nearest.
    function automatic int lut_value(int k, int wavelength, int data_width);
        real peak, v;
        peak = real'((1 << (data_width - 1)) - 1);
        v = peak * $sin(2.0 * PI * real'(k) / real'(wavelength));
        return (1 << (data_width - 1)) + int'($floor(v + 0.5));
    endfunction

    // Carrier offset in half-period units for the next symbol.
    function automatic logic next_offset(logic differential, logic offset, logic symbol);
        return differential ? offset ^ symbol : symbol;
    endfunction
endpackage

// File: rtl/bpsk_sine_lut.sv
// bpsk_sine_lut: registered full-period sine table.
//   clk, rst_n : clock, synchronous active-low reset (output returns to mid-scale)
//   en         : load a new sample this cycle
//   mute       : load mid-scale instead of the table entry
//   idx        : table index 0..WAVELENGTH-1
//   amp        : registered offset-binary sample
module bpsk_sine_lut
    import bpsk_pkg::*;
#(
    parameter int WAVELENGTH = 14,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          mute,
    input  logic [$clog2(WAVELENGTH)-1:0] idx,
    output logic [DATA_WIDTH-1:0]         amp
);
    localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    logic [DATA_WIDTH-1:0] rom [WAVELENGTH];

    for (genvar k = 0; k < WAVELENGTH; k++) begin : g_rom
        assign rom[k] = DATA_WIDTH'(lut_value(k, WAVELENGTH, DATA_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            amp <= MID;
        else if (en)
            amp <= mute ? MID : rom[idx];
    end
endmodule

// File: rtl/bpsk_modulator.sv
// bpsk_modulator: byte-stream BPSK/DBPSK transmitter with input FIFO and sine carrier.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_data/in_valid    : byte stream input, accepted when in_ready
//   in_ready            : FIFO not full
//   amp/amp_valid       : offset-binary carrier sample and its one-cycle update strobe
//   bit_out             : symbol bit currently on air (0 when idle)
//   busy                : transmitting
//   fifo_level          : bytes buffered
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int WAVELENGTH        = 14,
    parameter int CYCLES_PER_SAMPLE = 4,
    parameter int CARRIERS_PER_BIT  = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter bit DIFFERENTIAL      = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BYTE_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         amp,
    output logic                          amp_valid,
    output logic                          bit_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int PW  = $clog2(WAVELENGTH);
    localparam int PW1 = PW + 1;
    localparam int BW  = $clog2(BYTE_WIDTH);
    localparam int DVW = CYCLES_PER_SAMPLE > 1 ? $clog2(CYCLES_PER_SAMPLE) : 1;
    localparam int CW  = CARRIERS_PER_BIT > 1 ? $clog2(CARRIERS_PER_BIT) : 1;

    localparam logic [AW:0]    FULL_COUNT = AW1'(FIFO_DEPTH);
    localparam logic [PW-1:0]  PHASE_MAX  = PW'(WAVELENGTH - 1);
    localparam logic [PW:0]    HALF       = PW1'(WAVELENGTH / 2);
    localparam logic [PW:0]    PERIOD     = PW1'(WAVELENGTH);
    localparam logic [CW-1:0]  CC_MAX     = CW'(CARRIERS_PER_BIT - 1);
    localparam logic [DVW-1:0] DIV_MAX    = DVW'(CYCLES_PER_SAMPLE - 1);
    localparam logic [BW-1:0]  TOP_BIT    = BW'(BYTE_WIDTH - 1);

    if (!bpsk_params_ok(DATA_WIDTH, WAVELENGTH, CYCLES_PER_SAMPLE, CARRIERS_PER_BIT, FIFO_DEPTH)) begin : g_bad_params
        $error("bpsk_modulator: illegal parameter set");
    end

    logic [BYTE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  push, pop, empty;
    logic [BYTE_WIDTH-1:0] head;

    logic [DVW-1:0]        div;
    logic                  tick;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [CW-1:0]         cc_q, cc_d;
    logic [BW-1:0]         bidx_q, bidx_d;
    logic [BYTE_WIDTH-1:0] shreg_q, shreg_d;
    logic                  off_q, off_d;
    logic                  phase_wrap, cc_wrap, bit_end;

    logic [PW:0]           idx_sum;
    logic [PW-1:0]         idx;

    assign empty      = count == '0;
    assign in_ready   = count != FULL_COUNT;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign fifo_level = count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + AW1'(push) - AW1'(pop);
        end
    end

    assign tick = div == DIV_MAX;

    always_ff @(posedge clk) begin
        if (!rst_n)
            div <= '0;
        else
            div <= tick ? '0 : div + 1'b1;
    end

    assign phase_wrap = phase_q == PHASE_MAX;
    assign cc_wrap    = cc_q == CC_MAX;
    assign bit_end    = phase_wrap && cc_wrap;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cc_d    = cc_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        off_d   = off_q;
        pop     = 1'b0;
        if (state_q == IDLE) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = SEND;
                shreg_d = head;
                bidx_d  = TOP_BIT;
                phase_d = '0;
                cc_d    = '0;
                off_d   = next_offset(DIFFERENTIAL, off_q, head[BYTE_WIDTH-1]);
            end
        end else if (tick) begin
            phase_d = phase_wrap ? '0 : phase_q + 1'b1;
            if (phase_wrap)
                cc_d = cc_wrap ? '0 : cc_q + 1'b1;
            if (bit_end) begin
                if (bidx_q != '0) begin
                    bidx_d = bidx_q - 1'b1;
                    off_d  = next_offset(DIFFERENTIAL, off_q, shreg_q[bidx_q - 1'b1]);
                end else if (!empty) begin
                    // Next byte follows with no gap; phase/carrier counters have just wrapped.
                    pop     = 1'b1;
                    shreg_d = head;
                    bidx_d  = TOP_BIT;
                    off_d   = next_offset(DIFFERENTIAL, off_q, head[BYTE_WIDTH-1]);
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            cc_q      <= '0;
            bidx_q    <= '0;
            shreg_q   <= '0;
            off_q     <= 1'b0;
            amp_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cc_q      <= cc_d;
            bidx_q    <= bidx_d;
            shreg_q   <= shreg_d;
            off_q     <= off_d;
            amp_valid <= tick;
        end
    end

    assign busy    = state_q == SEND;
    assign bit_out = busy && shreg_q[bidx_q];

    // Phase shift of 180 deg is a half-period index offset.
    assign idx_sum = {1'b0, phase_q} + (off_q ? HALF : '0);
    assign idx     = PW'(idx_sum >= PERIOD ? idx_sum - PERIOD : idx_sum);

    bpsk_sine_lut #(
        .WAVELENGTH(WAVELENGTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_lut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (tick),
        .mute (state_q == IDLE),
        .idx  (idx),
        .amp  (amp)
    );
endmodule

// File: tb/tb_bpsk_modulator.sv
// tb_bpsk_modulator: directed + random checks of bpsk_modulator (NRZ and differential) against a symbol-level model.
module tb_bpsk_modulator;
    localparam int WL    = 14;
    localparam int CPS   = 4;
    localparam int CPB   = 2;
    localparam int DEPTH = 4;
    localparam int MID   = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    bit         sel = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       rst_n_a, rst_n_b;

    logic       in_ready_a, amp_valid_a, bit_out_a, busy_a;
    logic [7:0] amp_a;
    logic [2:0] fifo_level_a;
    logic       in_ready_b, amp_valid_b, bit_out_b, busy_b;
    logic [7:0] amp_b;
    logic [2:0] fifo_level_b;

    always #5 clk = ~clk;

    assign rst_n_a = rst && !sel;
    assign rst_n_b = rst && sel;

    bpsk_modulator dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .amp(amp_a), .amp_valid(amp_valid_a), .bit_out(bit_out_a), .busy(busy_a), .fifo_level(fifo_level_a)
    );

    bpsk_modulator #(.DIFFERENTIAL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .amp(amp_b), .amp_valid(amp_valid_b), .bit_out(bit_out_b), .busy(busy_b), .fifo_level(fifo_level_b)
    );

    int errors = 0;
    int checks = 0;

    // Symbol-level reference: byte queue, sample count within the current symbol, carrier offset.
    bit         diff;
    logic [7:0] q[$];
    bit         sending;
    logic [7:0] cur;
    int         bitpos, s, off, cyc;
    int         e_amp, e_av;
    int         lut[WL];
    bit         ph3_on;
    int         ph3_exp0, ph3_exp1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        sending = 0;
        cur = '0;
        bitpos = 0;
        s = 0;
        off = 0;
        cyc = 0;
        e_amp = MID;
        e_av = 0;
    endtask

    function automatic int rule(int b);
        return diff ? (off ^ b) : b;
    endfunction

    task automatic step();
        bit tick, push_ok, ph3;
        int ph3_bit;
        ph3 = 0;
        ph3_bit = 0;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            tick = (cyc % CPS) == CPS - 1;
            cyc++;
            push_ok = in_valid && q.size() < DEPTH;
            e_av = int'(tick);
            if (tick) begin
                e_amp = sending ? lut[(s % WL + off * (WL / 2)) % WL] : MID;
                if (sending && s % WL == 3) begin
                    ph3 = 1;
                    ph3_bit = int'(cur[bitpos]);
                end
            end
            if (!sending) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    bitpos = 7;
                    s = 0;
                    off = rule(int'(cur[7]));
                    sending = 1;
                end
            end else if (tick) begin
                s++;
                if (s == WL * CPB) begin
                    s = 0;
                    if (bitpos > 0) begin
                        bitpos--;
                        off = rule(int'(cur[bitpos]));
                    end else if (q.size() > 0) begin
                        cur = q.pop_front();
                        bitpos = 7;
                        off = rule(int'(cur[7]));
                    end else begin
                        sending = 0;
                    end
                end
            end
            if (push_ok) q.push_back(in_data);
        end
        #1;
        check("in_ready",   sel ? in_ready_b : in_ready_a,     q.size() < DEPTH);
        check("fifo_level", sel ? fifo_level_b : fifo_level_a, q.size());
        check("busy",       sel ? busy_b : busy_a,             sending);
        check("bit_out",    sel ? bit_out_b : bit_out_a,       sending ? cur[bitpos] : 1'b0);
        check("amp",        sel ? amp_b : amp_a,               e_amp);
        check("amp_valid",  sel ? amp_valid_b : amp_valid_a,   e_av);
        if (ph3_on && ph3)
            check("phase3_sample", sel ? amp_b : amp_a, ph3_bit != 0 ? ph3_exp1 : ph3_exp0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc;
        acc = 0;
        in_data = b;
        in_valid = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            acc = q.size() < DEPTH;
            step();
        end
        in_valid = 1'b0;
        check("push_accepted", acc, 1'b1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sending || q.size() > 0); i++)
            step();
        check("drain_busy",  sel ? busy_b : busy_a,             1'b0);
        check("drain_level", sel ? fifo_level_b : fifo_level_a, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++)
            step();
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] fill[6];
        int n, budget;
        bit acc;
        real v;
        for (int k = 0; k < WL; k++) begin
            v = 127.0 * $sin(2.0 * 3.141592653589793 * k / WL);
            lut[k] = MID + (v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
        end
        fill = '{8'h11, 8'h22, 8'h4B, 8'h96, 8'hE7, 8'h3C};

        // NRZ instance
        sel = 1'b0;
        diff = 1'b0;
        ph3_on = 1'b1;
        ph3_exp0 = 252;
        ph3_exp1 = 4;
        model_reset();
        in_valid = 1'b1;
        in_data = 8'h5A;
        do_reset(5);
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++)
            step();

        push_byte(8'hA5);
        drain(1200);
        for (int i = 0; i < 9; i++)
            step();

        push_byte(8'hFF);
        push_byte(8'h00);
        drain(2200);

        n = 0;
        budget = 0;
        while (n < 6 && budget < 8000) begin
            in_data = fill[n];
            in_valid = 1'b1;
            acc = q.size() < DEPTH;
            step();
            if (acc) n++;
            budget++;
        end
        in_valid = 1'b0;
        check("fill_all_pushed", n, 6);
        drain(7000);

        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'hC3);
        for (int i = 0; i < 300; i++)
            step();
        do_reset(1);
        for (int i = 0; i < 5; i++)
            step();

        for (int i = 0; i < 5; i++) begin
            push_byte(8'($urandom));
            for (int j = $urandom_range(0, 40); j > 0; j--)
                step();
        end
        drain(6000);

        // Differential instance
        sel = 1'b1;
        diff = 1'b1;
        ph3_exp0 = 4;
        ph3_exp1 = 4;
        do_reset(3);
        push_byte(8'h80);
        drain(1200);

        ph3_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'($urandom));
            for (int j = $urandom_range(0, 30); j > 0; j--)
                step();
        end
        drain(5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
